// File: rtl/speed_limit_pkg.sv
// Shared types and constants for the speed-limit arbiter.
// Defining SPEED_CLAMP_EN caps every latched target at CLAMP_MAX.
package speed_limit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRamp = 2'd1,
        StHold = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SrcNone   = 2'd0,
        SrcDriver = 2'd1,
        SrcSign   = 2'd2,
        SrcEmerg  = 2'd3
    } source_e;

    localparam logic [7:0] CLAMP_MAX = 8'd130;

endpackage

// File: rtl/limit_ramp.sv
// Next-value datapath for the applied limit: immediate decrease, rate-limited increase.
module limit_ramp #(
    parameter int unsigned STEP = 5
) (
    input  logic [7:0] cur,
    input  logic [7:0] target,
    output logic [7:0] next,
    output logic       done
);

    logic [8:0] sum;

    // 9-bit sum so a large step near 255 saturates at target instead of wrapping
    assign sum = {1'b0, cur} + 9'(STEP);

    always_comb begin
        if (target < cur) begin
            next = target;
        end else if (sum > {1'b0, target}) begin
            next = target;
        end else begin
            next = sum[7:0];
        end
    end

    assign done = (next == target);

endmodule

// File: rtl/speed_limit_arbiter.sv
// Fixed-priority speed-limit arbiter with ramped increases and minimum grant hold.
// Optional build macro: SPEED_CLAMP_EN clamps latched targets to CLAMP_MAX.
module speed_limit_arbiter
    import speed_limit_pkg::*;
#(
    parameter int unsigned STEP          = 5,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned DEFAULT_LIMIT = 60
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       driver_req,
    input  logic [7:0] driver_limit,
    input  logic       sign_req,
    input  logic [7:0] sign_limit,
    input  logic       emerg_req,
    input  logic [7:0] emerg_limit,
    output logic       driver_ack,
    output logic       sign_ack,
    output logic       emerg_ack,
    output logic [7:0] speed_limit,
    output logic       limit_valid,
    output logic [1:0] source,
    output logic       busy
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e             state_q, state_d;
    source_e            source_q, source_d;
    logic [7:0]         target_q, target_d;
    logic [7:0]         speed_q, speed_d;
    logic               valid_q, valid_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [2:0]         ack_q, ack_d;

    source_e            grant_src;
    logic [7:0]         grant_limit;
    logic [7:0]         grant_target;
    logic               grant;
    logic [7:0]         ramp_next;
    logic               ramp_done;

    limit_ramp #(
        .STEP (STEP)
    ) u_limit_ramp (
        .cur    (speed_q),
        .target (target_q),
        .next   (ramp_next),
        .done   (ramp_done)
    );

    always_comb begin
        grant_src   = SrcNone;
        grant_limit = 8'd0;
        if (emerg_req) begin
            grant_src   = SrcEmerg;
            grant_limit = emerg_limit;
        end else if (sign_req) begin
            grant_src   = SrcSign;
            grant_limit = sign_limit;
        end else if (driver_req) begin
            grant_src   = SrcDriver;
            grant_limit = driver_limit;
        end
`ifdef SPEED_CLAMP_EN
        grant_target = (grant_limit > CLAMP_MAX) ? CLAMP_MAX : grant_limit;
`else
        grant_target = grant_limit;
`endif
    end

    // Only an emergency may interrupt an active grant, and never another emergency
    assign grant = ((state_q == StIdle) && (grant_src != SrcNone)) ||
                   ((state_q != StIdle) && emerg_req && (source_q != SrcEmerg));

    always_comb begin
        state_d  = state_q;
        source_d = source_q;
        target_d = target_q;
        speed_d  = speed_q;
        valid_d  = valid_q;
        hold_d   = hold_q;
        ack_d    = 3'b000;

        case (state_q)
            StRamp: begin
                speed_d = ramp_next;
                if (ramp_done) begin
                    state_d = StHold;
                    hold_d  = HoldW'(HOLD_CYCLES - 1);
                    valid_d = 1'b1;
                end
            end
            StHold: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (grant) begin
            state_d  = StRamp;
            source_d = grant_src;
            target_d = grant_target;
            speed_d  = speed_q;
            valid_d  = 1'b0;
            case (grant_src)
                SrcDriver: ack_d = 3'b001;
                SrcSign:   ack_d = 3'b010;
                SrcEmerg:  ack_d = 3'b100;
                default:   ack_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            source_q <= SrcNone;
            target_q <= 8'(DEFAULT_LIMIT);
            speed_q  <= 8'(DEFAULT_LIMIT);
            valid_q  <= 1'b0;
            hold_q   <= '0;
            ack_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            source_q <= source_d;
            target_q <= target_d;
            speed_q  <= speed_d;
            valid_q  <= valid_d;
            hold_q   <= hold_d;
            ack_q    <= ack_d;
        end
    end

    assign driver_ack  = ack_q[0];
    assign sign_ack    = ack_q[1];
    assign emerg_ack   = ack_q[2];
    assign speed_limit = speed_q;
    assign limit_valid = valid_q;
    assign source      = source_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_speed_limit_arbiter.sv
// Directed bench for speed_limit_arbiter: main instance (STEP 5) and a STEP 10 instance.
module tb_speed_limit_arbiter;

    logic       CLK;
    logic       rst;
    logic       driver_req, sign_req, emerg_req;
    logic [7:0] driver_limit, sign_limit, emerg_limit;
    logic       driver_ack, sign_ack, emerg_ack;
    logic [7:0] speed_limit;
    logic       limit_valid;
    logic [1:0] source;
    logic       busy;

    logic       b_driver_req, b_sign_req, b_emerg_req;
    logic [7:0] b_driver_limit, b_sign_limit, b_emerg_limit;
    logic       b_driver_ack, b_sign_ack, b_emerg_ack;
    logic [7:0] b_speed_limit;
    logic       b_limit_valid;
    logic [1:0] b_source;
    logic       b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    speed_limit_arbiter #(
        .STEP          (5),
        .HOLD_CYCLES   (8),
        .DEFAULT_LIMIT (60)
    ) u_dut (
        .CLK          (CLK),
        .rst          (rst),
        .driver_req   (driver_req),
        .driver_limit (driver_limit),
        .sign_req     (sign_req),
        .sign_limit   (sign_limit),
        .emerg_req    (emerg_req),
        .emerg_limit  (emerg_limit),
        .driver_ack   (driver_ack),
        .sign_ack     (sign_ack),
        .emerg_ack    (emerg_ack),
        .speed_limit  (speed_limit),
        .limit_valid  (limit_valid),
        .source       (source),
        .busy         (busy)
    );

    speed_limit_arbiter #(
        .STEP          (10),
        .HOLD_CYCLES   (2),
        .DEFAULT_LIMIT (60)
    ) u_dut_step10 (
        .CLK          (CLK),
        .rst          (rst),
        .driver_req   (b_driver_req),
        .driver_limit (b_driver_limit),
        .sign_req     (b_sign_req),
        .sign_limit   (b_sign_limit),
        .emerg_req    (b_emerg_req),
        .emerg_limit  (b_emerg_limit),
        .driver_ack   (b_driver_ack),
        .sign_ack     (b_sign_ack),
        .emerg_ack    (b_emerg_ack),
        .speed_limit  (b_speed_limit),
        .limit_valid  (b_limit_valid),
        .source       (b_source),
        .busy         (b_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++; if (speed_limit !== 8'd60) begin n_fail++;
            $display("FAIL reset_speed: got %0d expected 60", speed_limit); end
        n_checks++; if (limit_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b expected 0", limit_valid); end
        n_checks++; if (source !== 2'd0) begin n_fail++;
            $display("FAIL reset_source: got %0d expected 0", source); end
        n_checks++; if ({emerg_ack, sign_ack, driver_ack} !== 3'b000) begin n_fail++;
            $display("FAIL reset_acks: got %b expected 000", {emerg_ack, sign_ack, driver_ack}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (b_speed_limit !== 8'd60) begin n_fail++;
            $display("FAIL reset_speed_step10: got %0d expected 60", b_speed_limit); end
        rst = 1'b0;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || speed_limit !== 8'd60) begin n_fail++;
            $display("FAIL idle_after_reset: busy %b speed %0d expected 0 60", busy, speed_limit); end
    endtask

    task automatic test_ramp_up();
        driver_limit = 8'd80;
        driver_req   = 1'b1;
        @(negedge CLK);
        n_checks++; if ({emerg_ack, sign_ack, driver_ack} !== 3'b001) begin n_fail++;
            $display("FAIL ramp_ack: got %b expected 001", {emerg_ack, sign_ack, driver_ack}); end
        n_checks++; if (source !== 2'd1 || busy !== 1'b1 || limit_valid !== 1'b0) begin n_fail++;
            $display("FAIL ramp_grant_state: source %0d busy %b valid %b expected 1 1 0",
                     source, busy, limit_valid); end
        n_checks++; if (speed_limit !== 8'd60) begin n_fail++;
            $display("FAIL ramp_ack_cycle_speed: got %0d expected 60", speed_limit); end
        driver_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            n_checks++; if (speed_limit !== 8'(60 + 5 * i)) begin n_fail++;
                $display("FAIL ramp_step%0d: got %0d expected %0d", i, speed_limit, 60 + 5 * i); end
            n_checks++; if (limit_valid !== ((i == 4) ? 1'b1 : 1'b0)) begin n_fail++;
                $display("FAIL ramp_valid%0d: got %b expected %b", i, limit_valid, i == 4); end
        end
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            n_checks++; if (busy !== 1'b1 || limit_valid !== 1'b1 || speed_limit !== 8'd80) begin
                n_fail++;
                $display("FAIL hold%0d: busy %b valid %b speed %0d expected 1 1 80",
                         i, busy, limit_valid, speed_limit); end
        end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || limit_valid !== 1'b1 || speed_limit !== 8'd80 ||
                        source !== 2'd1) begin n_fail++;
            $display("FAIL hold_exit: busy %b valid %b speed %0d source %0d expected 0 1 80 1",
                     busy, limit_valid, speed_limit, source); end
    endtask

    task automatic test_simultaneous();
        int n;
        sign_limit   = 8'd40;
        driver_limit = 8'd100;
        sign_req     = 1'b1;
        driver_req   = 1'b1;
        @(negedge CLK);
        n_checks++; if ({emerg_ack, sign_ack, driver_ack} !== 3'b010 || source !== 2'd2) begin
            n_fail++;
            $display("FAIL simul_sign_wins: acks %b source %0d expected 010 2",
                     {emerg_ack, sign_ack, driver_ack}, source); end
        sign_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (speed_limit !== 8'd40 || limit_valid !== 1'b1) begin n_fail++;
            $display("FAIL simul_decrease: speed %0d valid %b expected 40 1",
                     speed_limit, limit_valid); end
        n = 0;
        while (driver_ack !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        n_checks++; if (n != 9) begin n_fail++;
            $display("FAIL simul_driver_ack_delay: got %0d cycles expected 9", n); end
        driver_req = 1'b0;
        n_checks++; if (source !== 2'd1 || limit_valid !== 1'b0) begin n_fail++;
            $display("FAIL simul_driver_grant: source %0d valid %b expected 1 0",
                     source, limit_valid); end
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            n_checks++; if (speed_limit !== 8'(40 + 5 * i) ||
                            limit_valid !== ((i == 12) ? 1'b1 : 1'b0)) begin n_fail++;
                $display("FAIL simul_ramp%0d: speed %0d valid %b expected %0d %b",
                         i, speed_limit, limit_valid, 40 + 5 * i, i == 12); end
        end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL simul_idle_timeout: busy %b expected 0", busy); end
    endtask

    task automatic test_preempt();
        int n;
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        driver_limit = 8'd100;
        driver_req   = 1'b1;
        @(negedge CLK);
        driver_req = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (speed_limit !== 8'd70) begin n_fail++;
            $display("FAIL preempt_pre_speed: got %0d expected 70", speed_limit); end
        emerg_limit = 8'd20;
        emerg_req   = 1'b1;
        @(negedge CLK);
        n_checks++; if ({emerg_ack, sign_ack, driver_ack} !== 3'b100 || source !== 2'd3 ||
                        limit_valid !== 1'b0) begin n_fail++;
            $display("FAIL preempt_grant: acks %b source %0d valid %b expected 100 3 0",
                     {emerg_ack, sign_ack, driver_ack}, source, limit_valid); end
        emerg_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (speed_limit !== 8'd20 || limit_valid !== 1'b1) begin n_fail++;
            $display("FAIL preempt_speed: speed %0d valid %b expected 20 1",
                     speed_limit, limit_valid); end
        driver_limit = 8'd90;
        driver_req   = 1'b1;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (driver_ack === 1'b1) n++;
        end
        n_checks++; if (n != 0) begin n_fail++;
            $display("FAIL preempt_hold_no_ack: got %0d acks expected 0", n); end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || driver_ack !== 1'b0 || source !== 2'd3) begin n_fail++;
            $display("FAIL preempt_hold_end: busy %b ack %b source %0d expected 0 0 3",
                     busy, driver_ack, source); end
        @(negedge CLK);
        n_checks++; if (driver_ack !== 1'b1 || source !== 2'd1) begin n_fail++;
            $display("FAIL preempt_driver_later: ack %b source %0d expected 1 1",
                     driver_ack, source); end
        driver_req = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL preempt_idle_timeout: busy %b expected 0", busy); end
    endtask

    task automatic test_no_wrap();
        int n;
        logic [7:0] exp_hi;
        logic [7:0] exp_top;
        int exp_cyc;
`ifdef SPEED_CLAMP_EN
        exp_hi  = 8'd130;
        exp_top = 8'd130;
        exp_cyc = 7;
`else
        exp_hi  = 8'd245;
        exp_top = 8'd250;
        exp_cyc = 19;
`endif
        b_driver_limit = 8'd245;
        b_driver_req   = 1'b1;
        @(negedge CLK);
        n_checks++; if (b_driver_ack !== 1'b1) begin n_fail++;
            $display("FAIL step10_ack1: got %b expected 1", b_driver_ack); end
        b_driver_req = 1'b0;
        n = 0;
        while (b_limit_valid !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        n_checks++; if (n != exp_cyc) begin n_fail++;
            $display("FAIL step10_ramp_cycles: got %0d expected %0d", n, exp_cyc); end
        n_checks++; if (b_speed_limit !== exp_hi) begin n_fail++;
            $display("FAIL step10_first_target: got %0d expected %0d", b_speed_limit, exp_hi); end
        n = 0;
        while (b_busy !== 1'b0 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        b_driver_limit = 8'd250;
        b_driver_req   = 1'b1;
        @(negedge CLK);
        n_checks++; if (b_driver_ack !== 1'b1) begin n_fail++;
            $display("FAIL step10_ack2: got %b expected 1", b_driver_ack); end
        b_driver_req = 1'b0;
        @(negedge CLK);
        n_checks++; if (b_speed_limit !== exp_top || b_limit_valid !== 1'b1) begin n_fail++;
            $display("FAIL step10_no_wrap: speed %0d valid %b expected %0d 1",
                     b_speed_limit, b_limit_valid, exp_top); end
    endtask

    task automatic test_reset_mid_ramp();
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        driver_limit = 8'd100;
        driver_req   = 1'b1;
        @(negedge CLK);
        driver_req = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (speed_limit !== 8'd75) begin n_fail++;
            $display("FAIL midramp_speed: got %0d expected 75", speed_limit); end
        driver_req = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (speed_limit !== 8'd60 || limit_valid !== 1'b0 || source !== 2'd0 ||
                        busy !== 1'b0) begin n_fail++;
            $display("FAIL async_reset: speed %0d valid %b source %0d busy %b expected 60 0 0 0",
                     speed_limit, limit_valid, source, busy); end
        @(negedge CLK);
        n_checks++; if (driver_ack !== 1'b0 || speed_limit !== 8'd60) begin n_fail++;
            $display("FAIL reset_held: ack %b speed %0d expected 0 60", driver_ack, speed_limit); end
        rst = 1'b0;
        @(negedge CLK);
        n_checks++; if (driver_ack !== 1'b1 || source !== 2'd1) begin n_fail++;
            $display("FAIL rearbitrate: ack %b source %0d expected 1 1", driver_ack, source); end
        driver_req = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        driver_req     = 1'b0;
        sign_req       = 1'b0;
        emerg_req      = 1'b0;
        driver_limit   = 8'd0;
        sign_limit     = 8'd0;
        emerg_limit    = 8'd0;
        b_driver_req   = 1'b0;
        b_sign_req     = 1'b0;
        b_emerg_req    = 1'b0;
        b_driver_limit = 8'd0;
        b_sign_limit   = 8'd0;
        b_emerg_limit  = 8'd0;

        test_reset();
        test_ramp_up();
        test_simultaneous();
        test_preempt();
        test_no_wrap();
        test_reset_mid_ramp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
